bfly_tw_stage: RTL and testbench
================================

BFLY_TW_STAGE -- requirements
Module: bfly_tw_stage

Interface
REQ-001 Parameter IN_W, default 10, signed input sample width (real and imaginary).
REQ-002 Parameter OUT_W, default 12, signed output width; SHALL be >= IN_W+1.
REQ-003 Parameter LANES, default 16, parallel butterflies per beat.
REQ-004 Parameter TW_W, default 10, signed twiddle width; TW_FRAC, default 8, twiddle fraction bits.
REQ-005 Parameter TW_DEPTH, default 8 (power of 2), twiddle table entries; BLK_PER_TW, default 4 (power of 2), beats per twiddle index.
REQ-006 Parameter MODE, default 0: 0 = twiddle on difference only; 1 = twiddle on sum and difference. ROUND, default 1: 1 = round-half-up, 0 = truncate.
REQ-007 clk  in  1  clock; all state updates on rising edge.
REQ-008 rstn  in  1  reset, asynchronous, active-low.
REQ-009 in_valid  in  1 / in_ready  out  1  input handshake; beat accepted when both high.
REQ-010 in_sof  in  1  first beat of frame, qualified by acceptance.
REQ-011 in_a_re, in_a_im, in_b_re, in_b_im  in  LANES*IN_W each  packed lanes, lane j at bits [j*IN_W +: IN_W].
REQ-012 out_valid  out  1 / out_ready  in  1  output handshake.
REQ-013 out_sof  out  1  in_sof delayed with its beat.
REQ-014 out_a_re, out_a_im, out_b_re, out_b_im  out  LANES*OUT_W each  packed results.
REQ-015 tw_we  in  1; tw_addr  in  clog2(TW_DEPTH); tw_wre, tw_wim  in  TW_W each  twiddle table write port.
REQ-016 sat_flag  out  1  sticky saturation indicator; sat_clr  in  1  clears it.

Function
REQ-017 Per lane: s = a + b, d = a - b, complex, IN_W+1 bits, no overflow.
REQ-018 Complex multiply x*W: re = xr*wr - xi*wi, im = xr*wi + xi*wr, full precision; ROUND=1 adds 2^(TW_FRAC-1) before arithmetic right shift by TW_FRAC; ROUND=0 shifts only.
REQ-019 Shifted products SHALL saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; any saturating lane/component sets sat_flag.
REQ-020 MODE=0: out_a = s sign-extended, out_b = d*W. MODE=1: out_a = s*W, out_b = d*W.
REQ-021 Beat counter bc increments on each accepted beat, wraps at TW_DEPTH*BLK_PER_TW; accepted beat with in_sof=1 uses bc=0 and sets bc=1 afterwards.
REQ-022 Twiddle index for a beat = bc / BLK_PER_TW, sampled at acceptance.
REQ-023 Twiddle table: TW_DEPTH registers, written on tw_we; write visible to beats accepted in following cycles; simultaneous write and acceptance reading same address uses old value.
REQ-024 Pipeline: two register stages (S1: sum/diff + twiddle fetch; S2: multiply/round/saturate); latency exactly 2 cycles acceptance-to-out_valid with out_ready held high; throughput one beat per cycle.
REQ-025 Stage advances when empty or downstream accepts; in_ready = !S1_valid || S1 advancing; combinational out_ready->in_ready path permitted.
REQ-026 While out_valid=1 and out_ready=0, all outputs SHALL hold stable; no beat dropped, duplicated or reordered.
REQ-027 sat_clr and a new saturation in same cycle: sat_flag = 1.

Reset
REQ-028 rstn low: out_valid=0, in_ready=1 after release, out_sof=0, all data outputs 0, sat_flag=0, bc=0, in-flight beats discarded.
REQ-029 rstn low: every table entry = (2^TW_FRAC, 0), i.e. (256, 0) by default.
REQ-030 Reset asserted mid-stream SHALL take effect immediately, independent of clk.

Verification
REQ-031 Defaults, table at reset, all lanes a=(100,0), b=(20,0), sof=1 -> 2 cycles later out_a=(120,0), out_b=(80,0), out_sof=1.
REQ-032 Write entry 1=(181,-181); sof then 8 beats a=(100,0), b=(20,0) -> beats 0-3 out_b=(80,0); beats 4-7 out_b=(57,-57).
REQ-033 Entry 0=(-512,-512), a=(-512,-512), b=(511,511) -> out_b=(0,2047), sat_flag=1; sat_clr pulse -> sat_flag=0.
REQ-034 Continuous input, out_ready low 5 cycles -> in_ready low after 2 beats buffered, outputs held, all beats delivered in order after release.
REQ-035 Reset asserted with 2 beats in flight -> out_valid=0 same cycle; post-reset beat without sof uses index 0 and unity twiddle.
REQ-036 MODE=1, ROUND=0, entry 0=(0,-256), a=(3,1), b=(1,1) -> out_a=(2,-4), out_b=(0,-2).

Source files
------------

// File: rtl/bfly_tw_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : bfly_tw_stage_if                                       |
// | Description : Input/output stream bundle for the butterfly/twiddle   |
// |               stage: valid/ready handshakes, frame marker and the    |
// |               packed per-lane complex operands/results.              |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
interface bfly_tw_stage_if #(
  parameter int IN_W  = 10,
  parameter int OUT_W = 12,
  parameter int LANES = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_sof;
  logic [LANES*IN_W-1:0]  in_a_re;
  logic [LANES*IN_W-1:0]  in_a_im;
  logic [LANES*IN_W-1:0]  in_b_re;
  logic [LANES*IN_W-1:0]  in_b_im;

  logic                   out_valid;
  logic                   out_ready;
  logic                   out_sof;
  logic [LANES*OUT_W-1:0] out_a_re;
  logic [LANES*OUT_W-1:0] out_a_im;
  logic [LANES*OUT_W-1:0] out_b_re;
  logic [LANES*OUT_W-1:0] out_b_im;

  // Source of beats / sink of results (testbench or upstream logic)
  modport master (
    output in_valid, in_sof, in_a_re, in_a_im, in_b_re, in_b_im, out_ready,
    input  in_ready, out_valid, out_sof, out_a_re, out_a_im, out_b_re, out_b_im
  );

  // The butterfly stage itself
  modport slave (
    input  in_valid, in_sof, in_a_re, in_a_im, in_b_re, in_b_im, out_ready,
    output in_ready, out_valid, out_sof, out_a_re, out_a_im, out_b_re, out_b_im
  );
endinterface
`default_nettype wire

// File: rtl/bfly_tw_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : bfly_tw_stage                                          |
// | Description : LANES parallel radix-2 butterflies with a run-time     |
// |               loaded twiddle table. S1 forms sum/difference and      |
// |               fetches the twiddle, S2 multiplies, rounds and         |
// |               saturates. Sticky saturation flag.                     |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module bfly_tw_stage #(
  parameter int IN_W       = 10,
  parameter int OUT_W      = 12,
  parameter int LANES      = 16,
  parameter int TW_W       = 10,
  parameter int TW_FRAC    = 8,
  parameter int TW_DEPTH   = 8,
  parameter int BLK_PER_TW = 4,
  parameter int MODE       = 0,
  parameter int ROUND      = 1
) (
  input  logic                        clk,
  input  logic                        rstn,
  bfly_tw_stage_if.slave              bus,
  input  logic                        tw_we,
  input  logic [$clog2(TW_DEPTH)-1:0] tw_addr,
  input  logic signed [TW_W-1:0]      tw_wre,
  input  logic signed [TW_W-1:0]      tw_wim,
  input  logic                        sat_clr,
  output logic                        sat_flag
);

  localparam int TW_AW  = $clog2(TW_DEPTH);
  localparam int BLK_SH = $clog2(BLK_PER_TW);
  localparam int BC_N   = TW_DEPTH * BLK_PER_TW;
  localparam int BC_W   = (BC_N > 1) ? $clog2(BC_N) : 1;
  localparam int S_W    = IN_W + 1;
  // Two full products summed plus rounding offset never exceed this width
  localparam int P_W    = IN_W + TW_W + 3;
  localparam int X_W    = (P_W > OUT_W + 1) ? P_W : OUT_W + 1;

  localparam logic signed [TW_W-1:0] TW_ONE  = TW_W'(64'd1 << TW_FRAC);
  localparam logic signed [X_W-1:0]  RND_C   = (ROUND != 0) ? X_W'((64'd1 << TW_FRAC) >> 1) : '0;
  localparam logic signed [X_W-1:0]  SAT_MAX = {{(X_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [X_W-1:0]  SAT_MIN = {{(X_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // Complex product, real part, at full precision
  function automatic logic signed [X_W-1:0] cm_re(
    input logic signed [S_W-1:0]  xr, input logic signed [S_W-1:0]  xi,
    input logic signed [TW_W-1:0] wr, input logic signed [TW_W-1:0] wi);
    return X_W'(xr) * X_W'(wr) - X_W'(xi) * X_W'(wi);
  endfunction

  // Complex product, imaginary part, at full precision
  function automatic logic signed [X_W-1:0] cm_im(
    input logic signed [S_W-1:0]  xr, input logic signed [S_W-1:0]  xi,
    input logic signed [TW_W-1:0] wr, input logic signed [TW_W-1:0] wi);
    return X_W'(xr) * X_W'(wi) + X_W'(xi) * X_W'(wr);
  endfunction

  // Round (optional), drop fraction bits, clamp; MSB of result flags a clamp
  function automatic logic [OUT_W:0] rnd_sat(input logic signed [X_W-1:0] p);
    logic signed [X_W-1:0] r;
    r = (p + RND_C) >>> TW_FRAC;
    if (r > SAT_MAX)      return {1'b1, SAT_MAX[OUT_W-1:0]};
    else if (r < SAT_MIN) return {1'b1, SAT_MIN[OUT_W-1:0]};
    else                  return {1'b0, r[OUT_W-1:0]};
  endfunction

  logic [BC_W-1:0]        bc_q, bc_d, bc_base;
  logic [TW_AW-1:0]       tw_idx;
  logic signed [TW_W-1:0] tw_re_q [TW_DEPTH];
  logic signed [TW_W-1:0] tw_re_d [TW_DEPTH];
  logic signed [TW_W-1:0] tw_im_q [TW_DEPTH];
  logic signed [TW_W-1:0] tw_im_d [TW_DEPTH];

  logic                   s1_valid_q, s1_valid_d, s1_sof_q, s1_sof_d;
  logic signed [S_W-1:0]  s1_sre_q [LANES];
  logic signed [S_W-1:0]  s1_sre_d [LANES];
  logic signed [S_W-1:0]  s1_sim_q [LANES];
  logic signed [S_W-1:0]  s1_sim_d [LANES];
  logic signed [S_W-1:0]  s1_dre_q [LANES];
  logic signed [S_W-1:0]  s1_dre_d [LANES];
  logic signed [S_W-1:0]  s1_dim_q [LANES];
  logic signed [S_W-1:0]  s1_dim_d [LANES];
  logic signed [TW_W-1:0] s1_wre_q, s1_wre_d, s1_wim_q, s1_wim_d;

  logic                   out_valid_q, out_valid_d, out_sof_q, out_sof_d;
  logic [LANES*OUT_W-1:0] out_are_q, out_are_d, out_aim_q, out_aim_d;
  logic [LANES*OUT_W-1:0] out_bre_q, out_bre_d, out_bim_q, out_bim_d;
  logic                   sat_flag_q, sat_flag_d, sat_hit;

  logic                   s2_ready, in_ready, accept;
  logic signed [S_W-1:0]  ar, ai, br, bi;
  logic [OUT_W:0]         rs_are, rs_aim, rs_bre, rs_bim;

  // Handshake and twiddle-index selection; an sof beat restarts the count at 0
  always_comb begin
    s2_ready = !out_valid_q || bus.out_ready;
    in_ready = !s1_valid_q || s2_ready;
    accept   = bus.in_valid && in_ready;
    bc_base  = bus.in_sof ? '0 : bc_q;
    tw_idx   = TW_AW'(bc_base >> BLK_SH);
  end

  // Twiddle table write port; reads in S1 see the pre-write contents
  always_comb begin
    tw_re_d = tw_re_q;
    tw_im_d = tw_im_q;
    if (tw_we) begin
      tw_re_d[tw_addr] = tw_wre;
      tw_im_d[tw_addr] = tw_wim;
    end
  end

  // S1: butterfly sum/difference, twiddle fetch, beat counter
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sof_d   = s1_sof_q;
    s1_sre_d   = s1_sre_q;
    s1_sim_d   = s1_sim_q;
    s1_dre_d   = s1_dre_q;
    s1_dim_d   = s1_dim_q;
    s1_wre_d   = s1_wre_q;
    s1_wim_d   = s1_wim_q;
    bc_d       = bc_q;
    ar = '0; ai = '0; br = '0; bi = '0;
    if (in_ready) s1_valid_d = bus.in_valid;
    if (accept) begin
      s1_sof_d = bus.in_sof;
      s1_wre_d = tw_re_q[tw_idx];
      s1_wim_d = tw_im_q[tw_idx];
      bc_d     = (bc_base == BC_W'(BC_N - 1)) ? '0 : bc_base + BC_W'(1);
      for (int j = 0; j < LANES; j++) begin
        ar = S_W'($signed(bus.in_a_re[j*IN_W +: IN_W]));
        ai = S_W'($signed(bus.in_a_im[j*IN_W +: IN_W]));
        br = S_W'($signed(bus.in_b_re[j*IN_W +: IN_W]));
        bi = S_W'($signed(bus.in_b_im[j*IN_W +: IN_W]));
        s1_sre_d[j] = ar + br;
        s1_sim_d[j] = ai + bi;
        s1_dre_d[j] = ar - br;
        s1_dim_d[j] = ai - bi;
      end
    end
  end

  // S2: twiddle multiply, round, saturate; sticky flag favours a new hit over clear
  always_comb begin
    out_valid_d = out_valid_q;
    out_sof_d   = out_sof_q;
    out_are_d   = out_are_q;
    out_aim_d   = out_aim_q;
    out_bre_d   = out_bre_q;
    out_bim_d   = out_bim_q;
    sat_hit     = 1'b0;
    rs_are = '0; rs_aim = '0; rs_bre = '0; rs_bim = '0;
    if (s2_ready) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_sof_d = s1_sof_q;
        for (int j = 0; j < LANES; j++) begin
          rs_bre = rnd_sat(cm_re(s1_dre_q[j], s1_dim_q[j], s1_wre_q, s1_wim_q));
          rs_bim = rnd_sat(cm_im(s1_dre_q[j], s1_dim_q[j], s1_wre_q, s1_wim_q));
          if (MODE != 0) begin
            rs_are = rnd_sat(cm_re(s1_sre_q[j], s1_sim_q[j], s1_wre_q, s1_wim_q));
            rs_aim = rnd_sat(cm_im(s1_sre_q[j], s1_sim_q[j], s1_wre_q, s1_wim_q));
          end else begin
            rs_are = {1'b0, OUT_W'(s1_sre_q[j])};
            rs_aim = {1'b0, OUT_W'(s1_sim_q[j])};
          end
          out_are_d[j*OUT_W +: OUT_W] = rs_are[OUT_W-1:0];
          out_aim_d[j*OUT_W +: OUT_W] = rs_aim[OUT_W-1:0];
          out_bre_d[j*OUT_W +: OUT_W] = rs_bre[OUT_W-1:0];
          out_bim_d[j*OUT_W +: OUT_W] = rs_bim[OUT_W-1:0];
          sat_hit = sat_hit | rs_are[OUT_W] | rs_aim[OUT_W] | rs_bre[OUT_W] | rs_bim[OUT_W];
        end
      end
    end
    sat_flag_d = (sat_flag_q && !sat_clr) || sat_hit;
  end

  // State registers; reset aborts in-flight beats and restores unity twiddles
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bc_q <= '0;
      for (int k = 0; k < TW_DEPTH; k++) begin
        tw_re_q[k] <= TW_ONE;
        tw_im_q[k] <= '0;
      end
      s1_valid_q <= 1'b0;
      s1_sof_q   <= 1'b0;
      for (int j = 0; j < LANES; j++) begin
        s1_sre_q[j] <= '0;
        s1_sim_q[j] <= '0;
        s1_dre_q[j] <= '0;
        s1_dim_q[j] <= '0;
      end
      s1_wre_q    <= '0;
      s1_wim_q    <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_are_q   <= '0;
      out_aim_q   <= '0;
      out_bre_q   <= '0;
      out_bim_q   <= '0;
      sat_flag_q  <= 1'b0;
    end else begin
      bc_q        <= bc_d;
      tw_re_q     <= tw_re_d;
      tw_im_q     <= tw_im_d;
      s1_valid_q  <= s1_valid_d;
      s1_sof_q    <= s1_sof_d;
      s1_sre_q    <= s1_sre_d;
      s1_sim_q    <= s1_sim_d;
      s1_dre_q    <= s1_dre_d;
      s1_dim_q    <= s1_dim_d;
      s1_wre_q    <= s1_wre_d;
      s1_wim_q    <= s1_wim_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_are_q   <= out_are_d;
      out_aim_q   <= out_aim_d;
      out_bre_q   <= out_bre_d;
      out_bim_q   <= out_bim_d;
      sat_flag_q  <= sat_flag_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sof   = out_sof_q;
  assign bus.out_a_re  = out_are_q;
  assign bus.out_a_im  = out_aim_q;
  assign bus.out_b_re  = out_bre_q;
  assign bus.out_b_im  = out_bim_q;
  assign sat_flag      = sat_flag_q;

endmodule
`default_nettype wire

// File: tb/tb_bfly_tw_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_bfly_tw_stage                                       |
// | Description : Directed self-checking bench for bfly_tw_stage         |
// |               (default build plus a MODE=1/ROUND=0 build).           |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_bfly_tw_stage;
  localparam int IN_W  = 10;
  localparam int OUT_W = 12;
  localparam int LANES = 16;
  localparam int TW_W  = 10;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  bfly_tw_stage_if #(.IN_W(IN_W), .OUT_W(OUT_W), .LANES(LANES)) bus0 ();
  bfly_tw_stage_if #(.IN_W(IN_W), .OUT_W(OUT_W), .LANES(LANES)) bus1 ();

  logic                   tw_we0, tw_we1, sat_clr0, sat_clr1, sat_flag0, sat_flag1;
  logic [2:0]             tw_addr0, tw_addr1;
  logic signed [TW_W-1:0] tw_wre0, tw_wim0, tw_wre1, tw_wim1;

  bfly_tw_stage u_dut0 (
    .clk(clk), .rstn(rstn), .bus(bus0),
    .tw_we(tw_we0), .tw_addr(tw_addr0), .tw_wre(tw_wre0), .tw_wim(tw_wim0),
    .sat_clr(sat_clr0), .sat_flag(sat_flag0)
  );

  bfly_tw_stage #(.MODE(1), .ROUND(0)) u_dut1 (
    .clk(clk), .rstn(rstn), .bus(bus1),
    .tw_we(tw_we1), .tw_addr(tw_addr1), .tw_wre(tw_wre1), .tw_wim(tw_wim1),
    .sat_clr(sat_clr1), .sat_flag(sat_flag1)
  );

  int checks   = 0;
  int failures = 0;

  function automatic logic [LANES*IN_W-1:0] rep_i(input int v);
    logic [LANES*IN_W-1:0] r;
    for (int j = 0; j < LANES; j++) r[j*IN_W +: IN_W] = v[IN_W-1:0];
    return r;
  endfunction

  function automatic logic [LANES*OUT_W-1:0] rep_o(input int v);
    logic [LANES*OUT_W-1:0] r;
    for (int j = 0; j < LANES; j++) r[j*OUT_W +: OUT_W] = v[OUT_W-1:0];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [LANES*OUT_W-1:0] obs,
                     input logic [LANES*OUT_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_beat0(input logic sof, input int ar, input int ai, input int br, input int bi);
    bus0.in_sof  = sof;
    bus0.in_a_re = rep_i(ar);
    bus0.in_a_im = rep_i(ai);
    bus0.in_b_re = rep_i(br);
    bus0.in_b_im = rep_i(bi);
  endtask

  task automatic set_beat1(input logic sof, input int ar, input int ai, input int br, input int bi);
    bus1.in_sof  = sof;
    bus1.in_a_re = rep_i(ar);
    bus1.in_a_im = rep_i(ai);
    bus1.in_b_re = rep_i(br);
    bus1.in_b_im = rep_i(bi);
  endtask

  // Called at a falling edge; returns at the next falling edge
  task automatic tw_write0(input int addr, input int re, input int im);
    tw_we0 = 1'b1; tw_addr0 = 3'(addr); tw_wre0 = TW_W'(re); tw_wim0 = TW_W'(im);
    @(negedge clk);
    tw_we0 = 1'b0;
  endtask

  task automatic tw_write1(input int addr, input int re, input int im);
    tw_we1 = 1'b1; tw_addr1 = 3'(addr); tw_wre1 = TW_W'(re); tw_wim1 = TW_W'(im);
    @(negedge clk);
    tw_we1 = 1'b0;
  endtask

  int sent, got;
  logic acc, held_vld;
  logic [LANES*OUT_W-1:0] held_a;

  initial begin
    tw_we0 = 0; tw_addr0 = 0; tw_wre0 = 0; tw_wim0 = 0; sat_clr0 = 0;
    tw_we1 = 0; tw_addr1 = 0; tw_wre1 = 0; tw_wim1 = 0; sat_clr1 = 0;
    bus0.in_valid = 0; bus0.out_ready = 1; set_beat0(0, 0, 0, 0, 0);
    bus1.in_valid = 0; bus1.out_ready = 1; set_beat1(0, 0, 0, 0, 0);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", bus0.out_valid, 0);
    chk("rst_out_sof",   bus0.out_sof, 0);
    chk("rst_out_a_re",  bus0.out_a_re, 0);
    chk("rst_out_b_im",  bus0.out_b_im, 0);
    chk("rst_sat_flag",  sat_flag0, 0);
    rstn = 1'b1;
    #1 chk("rst_in_ready", bus0.in_ready, 1);
    @(negedge clk);

    // Unity twiddle, sof beat, two-cycle latency
    set_beat0(1, 100, 0, 20, 0); bus0.in_valid = 1;
    @(negedge clk); bus0.in_valid = 0;
    chk("lat_not_yet", bus0.out_valid, 0);
    @(negedge clk);
    chk("unity_valid", bus0.out_valid, 1);
    chk("unity_sof",   bus0.out_sof, 1);
    chk("unity_a_re",  bus0.out_a_re, rep_o(120));
    chk("unity_a_im",  bus0.out_a_im, rep_o(0));
    chk("unity_b_re",  bus0.out_b_re, rep_o(80));
    chk("unity_b_im",  bus0.out_b_im, rep_o(0));
    @(negedge clk);
    chk("unity_drain", bus0.out_valid, 0);

    // Index switches after BLK_PER_TW beats; entry 1 rotates by -45 deg
    tw_write0(1, 181, -181);
    for (int i = 0; i < 10; i++) begin
      if (i >= 2) begin
        chk("idx_valid", bus0.out_valid, 1);
        chk("idx_b_re",  bus0.out_b_re, rep_o((i - 2 < 4) ? 80 : 57));
        chk("idx_b_im",  bus0.out_b_im, rep_o((i - 2 < 4) ? 0 : -57));
        chk("idx_sof",   bus0.out_sof, (i == 2) ? 1 : 0);
      end
      if (i < 8) begin
        set_beat0(i == 0, 100, 0, 20, 0); bus0.in_valid = 1;
      end else begin
        bus0.in_valid = 0;
      end
      @(negedge clk);
    end

    // Saturation, clear, and clear colliding with a new hit
    tw_write0(0, -512, -512);
    chk("sat_before", sat_flag0, 0);
    set_beat0(1, -512, -512, 511, 511); bus0.in_valid = 1;
    @(negedge clk); bus0.in_valid = 0;
    @(negedge clk);
    chk("sat_b_re", bus0.out_b_re, rep_o(0));
    chk("sat_b_im", bus0.out_b_im, rep_o(2047));
    chk("sat_a_re", bus0.out_a_re, rep_o(-1));
    chk("sat_set",  sat_flag0, 1);
    sat_clr0 = 1;
    @(negedge clk); sat_clr0 = 0;
    chk("sat_cleared", sat_flag0, 0);
    bus0.in_valid = 1;
    @(negedge clk); bus0.in_valid = 0; sat_clr0 = 1;
    @(negedge clk); sat_clr0 = 0;
    chk("sat_clr_vs_hit", sat_flag0, 1);
    sat_clr0 = 1;
    @(negedge clk); sat_clr0 = 0;

    // Backpressure: ten beats streamed, sink stalls for five cycles
    sent = 0; got = 0; acc = 0; held_vld = 0; held_a = '0;
    for (int c = 0; c < 40; c++) begin
      if (acc) sent++;
      bus0.out_ready = !(c >= 3 && c < 8);
      #1;
      if (c == 7) chk("bp_in_ready_low", bus0.in_ready, 0);
      if (c == 9) chk("bp_in_ready_high", bus0.in_ready, 1);
      if (bus0.out_valid) begin
        if (bus0.out_ready) begin
          chk("bp_a_re", bus0.out_a_re, rep_o(11 * got + 5));
          chk("bp_a_im", bus0.out_a_im, rep_o(2 - got));
          got++;
          held_vld = 0;
        end else begin
          if (held_vld) chk("bp_hold", bus0.out_a_re, held_a);
          held_a = bus0.out_a_re;
          held_vld = 1;
        end
      end
      if (sent < 10) begin
        set_beat0(sent == 0, 10 * sent + 5, -sent, sent, 2); bus0.in_valid = 1;
      end else begin
        bus0.in_valid = 0;
      end
      acc = bus0.in_valid && bus0.in_ready;
      @(negedge clk);
    end
    chk("bp_count", 32'(got), 10);

    // Asynchronous reset with beats in flight, then table/counter defaults
    tw_write0(0, 0, 256);
    set_beat0(0, 100, 0, 20, 0); bus0.in_valid = 1;
    @(negedge clk);
    @(negedge clk); bus0.in_valid = 0;
    chk("inflight_valid", bus0.out_valid, 1);
    #2 rstn = 1'b0;
    #1 chk("async_rst_valid", bus0.out_valid, 0);
    chk("async_rst_b_re", bus0.out_b_re, 0);
    @(negedge clk); rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", bus0.out_valid, 0);
    for (int k = 1; k < 8; k++) tw_write0(k, 0, 256);
    set_beat0(0, 100, 0, 20, 0); bus0.in_valid = 1;
    @(negedge clk); bus0.in_valid = 0;
    @(negedge clk);
    chk("post_rst_valid", bus0.out_valid, 1);
    chk("post_rst_b_re",  bus0.out_b_re, rep_o(80));
    chk("post_rst_b_im",  bus0.out_b_im, rep_o(0));
    chk("post_rst_sof",   bus0.out_sof, 0);

    // MODE=1, truncation: -j twiddle, then a tiny twiddle exposing floor
    tw_write1(0, 0, -256);
    set_beat1(1, 3, 1, 1, 1); bus1.in_valid = 1;
    @(negedge clk); bus1.in_valid = 0;
    @(negedge clk);
    chk("m1_valid", bus1.out_valid, 1);
    chk("m1_a_re", bus1.out_a_re, rep_o(2));
    chk("m1_a_im", bus1.out_a_im, rep_o(-4));
    chk("m1_b_re", bus1.out_b_re, rep_o(0));
    chk("m1_b_im", bus1.out_b_im, rep_o(-2));
    tw_write1(0, 1, 0);
    set_beat1(1, 200, -200, 100, -100); bus1.in_valid = 1;
    @(negedge clk); bus1.in_valid = 0;
    @(negedge clk);
    chk("trunc_a_re", bus1.out_a_re, rep_o(1));
    chk("trunc_a_im", bus1.out_a_im, rep_o(-2));
    chk("trunc_b_re", bus1.out_b_re, rep_o(0));
    chk("trunc_b_im", bus1.out_b_im, rep_o(-1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
